jtcop_prot_bridge: RTL and testbench

- Main-CPU-side responder for the protection MCU's 2 kB shared mailbox RAM.
- Accepts 68000 byte accesses, sequences them onto the shared RAM's main port, and returns an acknowledge for DTACK generation.
- Arbitrates against a busy flag from the MCU side.
- Generates and holds the mailbox interrupt to the MCU when the doorbell byte is written.

---
 rtl/jtcop_prot_bridge.sv | 138 +++++++++++++
 tb/tb_jtcop_prot_bridge.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtcop_prot_bridge.sv
// Main-CPU side of the protection MCU mailbox RAM: sequences 68000 byte accesses
// onto the shared RAM port, returns an acknowledge and drives the doorbell interrupt.
module jtcop_prot_bridge #(
  parameter int            AW       = 11,
  parameter logic [AW-1:0] IRQ_ADDR = '1,
  parameter int            RAM_LAT  = 1,
  parameter int            IRQ_HOLD = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_cen,
  input  logic          main_cs,
  input  logic          main_wrn,
  input  logic [AW-1:0] main_addr,
  input  logic [7:0]    main_dout,
  output logic [7:0]    main_din,
  output logic          main_ok,
  output logic [AW-1:0] ram_addr,
  output logic [7:0]    ram_data,
  output logic          ram_we,
  input  logic [7:0]    ram_q,
  input  logic          mcu_busy,
  input  logic          mcu_ack,
  output logic          mcu_irqn
);

  localparam int HW = (IRQ_HOLD > 0) ? $clog2(IRQ_HOLD + 1) : 1;

  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

  state_t        state_reg, state_next;
  logic [1:0]    lat_reg, lat_next;
  logic [AW-1:0] ram_addr_reg, ram_addr_next;
  logic [7:0]    ram_data_reg, ram_data_next;
  logic          ram_we_reg, ram_we_next;
  logic [7:0]    main_din_reg, main_din_next;
  logic          main_ok_reg, main_ok_next;
  logic          irq_reg, irq_next;
  logic [HW-1:0] hold_reg, hold_next;
  logic          irq_set;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      lat_reg      <= 2'd0;
      ram_addr_reg <= '0;
      ram_data_reg <= 8'h00;
      ram_we_reg   <= 1'b0;
      main_din_reg <= 8'hff;
      main_ok_reg  <= 1'b0;
      irq_reg      <= 1'b0;
      hold_reg     <= '0;
    end else begin
      state_reg    <= state_next;
      lat_reg      <= lat_next;
      ram_addr_reg <= ram_addr_next;
      ram_data_reg <= ram_data_next;
      ram_we_reg   <= ram_we_next;
      main_din_reg <= main_din_next;
      main_ok_reg  <= main_ok_next;
      irq_reg      <= irq_next;
      hold_reg     <= hold_next;
    end
  end

  // The write strobe and the doorbell are both registered on the accepting edge,
  // so the interrupt asserts in the same cycle the RAM sees ram_we.
  always_comb begin
    state_next    = state_reg;
    lat_next      = lat_reg;
    ram_addr_next = ram_addr_reg;
    ram_data_next = ram_data_reg;
    ram_we_next   = 1'b0;
    main_din_next = main_din_reg;
    main_ok_next  = main_ok_reg;
    irq_set       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (cpu_cen && main_cs && !mcu_busy) begin
          ram_addr_next = main_addr;
          ram_data_next = main_dout;
          lat_next      = 2'd0;
          if (!main_wrn) begin
            state_next  = WRITE;
            ram_we_next = 1'b1;
            irq_set     = (main_addr == IRQ_ADDR);
          end else begin
            state_next  = READ;
          end
        end
      end
      WRITE: begin
        state_next   = DONE;
        main_ok_next = 1'b1;
      end
      READ: begin
        if (lat_reg == 2'(RAM_LAT - 1)) begin
          main_din_next = ram_q;
          main_ok_next  = 1'b1;
          state_next    = DONE;
        end else begin
          lat_next = lat_reg + 2'd1;
        end
      end
      DONE: begin
        if (cpu_cen && !main_cs) begin
          main_ok_next = 1'b0;
          state_next   = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A doorbell beats a simultaneous ack; a repeat doorbell reloads the hold time.
  always_comb begin
    irq_next  = irq_reg;
    hold_next = hold_reg;
    if (irq_set) begin
      irq_next  = 1'b1;
      hold_next = HW'(IRQ_HOLD);
    end else if (mcu_ack) begin
      irq_next  = 1'b0;
      hold_next = '0;
    end else if (IRQ_HOLD > 0 && irq_reg) begin
      hold_next = hold_reg - 1'b1;
      if (hold_reg == HW'(1)) irq_next = 1'b0;
    end
  end

  assign main_din = main_din_reg;
  assign main_ok  = main_ok_reg;
  assign ram_addr = ram_addr_reg;
  assign ram_data = ram_data_reg;
  assign ram_we   = ram_we_reg;
  assign mcu_irqn = ~irq_reg;

endmodule

// File: tb/tb_jtcop_prot_bridge.sv
// Bench for jtcop_prot_bridge: two instances (read latency 2 / held IRQ and
// read latency 1 / 4-cycle IRQ) share the CPU-side stimulus.
module tb_jtcop_prot_bridge;
  localparam int AW = 11;
  localparam logic [AW-1:0] DOORBELL = 11'h7ff;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cpu_cen = 1'b0, main_cs = 1'b0, main_wrn = 1'b1, mcu_busy = 1'b0, mcu_ack = 1'b0;
  logic [AW-1:0] main_addr = '0;
  logic [7:0] main_dout = 8'h00;

  logic [7:0]    din_o  [2];
  logic          ok_o   [2];
  logic [AW-1:0] ra_o   [2];
  logic [7:0]    rd_o   [2];
  logic          we_o   [2];
  logic [7:0]    rq_i   [2];
  logic          irqn_o [2];

  always #5 clk = ~clk;

  jtcop_prot_bridge #(.AW(AW), .RAM_LAT(2), .IRQ_HOLD(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .cpu_cen(cpu_cen), .main_cs(main_cs), .main_wrn(main_wrn),
    .main_addr(main_addr), .main_dout(main_dout), .main_din(din_o[0]), .main_ok(ok_o[0]),
    .ram_addr(ra_o[0]), .ram_data(rd_o[0]), .ram_we(we_o[0]), .ram_q(rq_i[0]),
    .mcu_busy(mcu_busy), .mcu_ack(mcu_ack), .mcu_irqn(irqn_o[0]));

  jtcop_prot_bridge #(.AW(AW), .RAM_LAT(1), .IRQ_HOLD(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .cpu_cen(cpu_cen), .main_cs(main_cs), .main_wrn(main_wrn),
    .main_addr(main_addr), .main_dout(main_dout), .main_din(din_o[1]), .main_ok(ok_o[1]),
    .ram_addr(ra_o[1]), .ram_data(rd_o[1]), .ram_we(we_o[1]), .ram_q(rq_i[1]),
    .mcu_busy(mcu_busy), .mcu_ack(mcu_ack), .mcu_irqn(irqn_o[1]));

  // Shared RAM stand-ins: untouched locations read a fixed hash of the address.
  function automatic logic [7:0] init_byte(input logic [AW-1:0] a);
    return 8'(a * 37 + 11) ^ 8'(a >> 3);
  endfunction

  bit [7:0] bram  [2][2048];
  bit       wflag [2][2048];
  always @(posedge clk) begin
    if (we_o[0]) begin bram[0][ra_o[0]] <= rd_o[0]; wflag[0][ra_o[0]] <= 1'b1; end
    if (we_o[1]) begin bram[1][ra_o[1]] <= rd_o[1]; wflag[1][ra_o[1]] <= 1'b1; end
  end
  assign rq_i[0] = wflag[0][ra_o[0]] ? bram[0][ra_o[0]] : init_byte(ra_o[0]);
  assign rq_i[1] = wflag[1][ra_o[1]] ? bram[1][ra_o[1]] : init_byte(ra_o[1]);

  // Reference model
  logic [7:0] ref_mem [2048];
  int   lat_p  [2] = '{2, 1};
  int   hold_p [2] = '{0, 4};
  bit   irq_lvl [2];
  int   irq_left [2];
  logic [7:0] last_din [2];
  int   ack_pct = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, d, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    n_cmp++;
    n_bad++;
    $error("FAIL %s timeout observed=no_progress expected=progress", tag);
  endtask

  function automatic logic rand_ack();
    return ($urandom_range(0, 99) < ack_pct);
  endfunction

  // Advance one clock; the IRQ model follows the latch/ack/hold rules.
  task automatic tick(input bit set_irq);
    for (int d = 0; d < 2; d++) begin
      if (set_irq) begin
        irq_lvl[d] = 1'b1; irq_left[d] = hold_p[d];
      end else if (mcu_ack) begin
        irq_lvl[d] = 1'b0; irq_left[d] = 0;
      end else if (hold_p[d] > 0 && irq_lvl[d]) begin
        irq_left[d]--;
        if (irq_left[d] == 0) irq_lvl[d] = 1'b0;
      end
    end
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++) chk("irqn", d, irqn_o[d], !irq_lvl[d]);
  endtask

  task automatic idle(input int n, input bit ack_on);
    for (int k = 0; k < n; k++) begin
      main_cs = 1'b0;
      cpu_cen = 1'($urandom_range(0, 1));
      mcu_busy = 1'($urandom_range(0, 1));
      mcu_ack = ack_on;
      tick(1'b0);
      for (int d = 0; d < 2; d++) begin
        chk("idle_ok", d, ok_o[d], 1'b0);
        chk("idle_we", d, we_o[d], 1'b0);
        chk("idle_din", d, din_o[d], last_din[d]);
      end
    end
    mcu_ack = 1'b0;
  endtask

  task automatic access(input bit wr, input logic [AW-1:0] addr, input logic [7:0] data,
                        input int busy_n, input bit abort, input bit force_ack, input bit rst_mid);
    int  busy_left = busy_n;
    bit  accepted = 1'b0;
    bit  acc;
    int  guard = 0;
    int  ok_edge [2];
    bit  ok_exp [2];
    bit  exited [2];
    int  i = 0;
    int  max_edge;
    main_cs = 1'b1; main_wrn = !wr; main_addr = addr; main_dout = data;
    while (!accepted && guard < 200) begin
      cpu_cen = 1'($urandom_range(0, 1));
      mcu_busy = (busy_left > 0);
      mcu_ack = rand_ack();
      acc = cpu_cen && !mcu_busy;
      if (cpu_cen && mcu_busy) busy_left--;
      if (acc && force_ack) mcu_ack = 1'b1;
      tick(acc && wr && addr == DOORBELL);
      guard++;
      if (acc) accepted = 1'b1;
      else for (int d = 0; d < 2; d++) begin
        chk("wait_we", d, we_o[d], 1'b0);
        chk("wait_ok", d, ok_o[d], 1'b0);
      end
    end
    if (!accepted) begin timeout("accept"); main_cs = 1'b0; return; end
    for (int d = 0; d < 2; d++) begin
      chk("acc_we", d, we_o[d], wr);
      chk("acc_ok", d, ok_o[d], 1'b0);
      if (wr) begin
        chk("acc_addr", d, ra_o[d], addr);
        chk("acc_data", d, rd_o[d], data);
      end
    end
    if (rst_mid) begin
      rst_n = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) begin
        irq_lvl[d] = 1'b0; irq_left[d] = 0; last_din[d] = 8'hff;
        chk("rst_din", d, din_o[d], 8'hff);
        chk("rst_ok", d, ok_o[d], 1'b0);
        chk("rst_we", d, we_o[d], 1'b0);
        chk("rst_addr", d, ra_o[d], 0);
        chk("rst_data", d, rd_o[d], 0);
        chk("rst_irqn", d, irqn_o[d], 1'b1);
      end
      @(posedge clk); #1;
      rst_n = 1'b1; main_cs = 1'b0; mcu_ack = 1'b0;
      return;
    end
    if (abort) main_cs = 1'b0;
    for (int d = 0; d < 2; d++) begin
      ok_edge[d] = wr ? 1 : lat_p[d];
      ok_exp[d] = 1'b0; exited[d] = 1'b0;
    end
    max_edge = (ok_edge[0] > ok_edge[1]) ? ok_edge[0] : ok_edge[1];
    guard = 0;
    while (!(exited[0] && exited[1]) && guard < 200) begin
      i++; guard++;
      if (i - 1 >= max_edge) main_cs = 1'b0;
      cpu_cen = 1'($urandom_range(0, 1));
      mcu_busy = 1'($urandom_range(0, 1));
      mcu_ack = rand_ack();
      for (int d = 0; d < 2; d++) begin
        if (ok_exp[d]) begin
          if (cpu_cen && !main_cs) begin ok_exp[d] = 1'b0; exited[d] = 1'b1; end
        end else if (i == ok_edge[d]) begin
          ok_exp[d] = 1'b1;
          if (!wr) last_din[d] = ref_mem[addr];
        end
      end
      tick(1'b0);
      for (int d = 0; d < 2; d++) begin
        chk("ok", d, ok_o[d], ok_exp[d]);
        chk("we_pulse", d, we_o[d], 1'b0);
        if (i >= ok_edge[d]) chk("din", d, din_o[d], last_din[d]);
      end
    end
    if (guard >= 200) timeout("done");
    if (wr) ref_mem[addr] = data;
    main_cs = 1'b0; mcu_ack = 1'b0;
    $display("access %s addr=%03h data=%02h busy=%0d abort=%0d ack=%0d", wr ? "WR" : "RD",
             addr, wr ? data : ref_mem[addr], busy_n, abort, force_ack);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int a = 0; a < 2048; a++) ref_mem[a] = init_byte(AW'(a));
    for (int d = 0; d < 2; d++) begin irq_lvl[d] = 1'b0; irq_left[d] = 0; last_din[d] = 8'hff; end

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("reset_din", d, din_o[d], 8'hff);
      chk("reset_ok", d, ok_o[d], 1'b0);
      chk("reset_we", d, we_o[d], 1'b0);
      chk("reset_addr", d, ra_o[d], 0);
      chk("reset_irqn", d, irqn_o[d], 1'b1);
    end
    rst_n = 1'b1;
    idle(2, 1'b0);

    // Plain write, then read back with latency
    access(1'b1, 11'h123, 8'h5a, 0, 1'b0, 1'b0, 1'b0);
    access(1'b1, 11'h010, 8'hc3, 0, 1'b0, 1'b0, 1'b0);
    access(1'b0, 11'h010, 8'h00, 0, 1'b0, 1'b0, 1'b0);
    idle(2, 1'b0);

    // Doorbell: held / auto-cleared, ack clears, set beats simultaneous ack
    access(1'b1, DOORBELL, 8'h01, 0, 1'b0, 1'b0, 1'b0);
    idle(6, 1'b0);
    access(1'b1, DOORBELL, 8'h01, 0, 1'b0, 1'b0, 1'b0);
    idle(1, 1'b1);
    idle(1, 1'b0);
    access(1'b1, DOORBELL, 8'h02, 0, 1'b0, 1'b1, 1'b0);
    idle(6, 1'b0);
    idle(1, 1'b1);

    // Busy arbitration, abort, doorbell read
    access(1'b1, 11'h234, 8'h99, 3, 1'b0, 1'b0, 1'b0);
    access(1'b0, 11'h234, 8'h00, 2, 1'b1, 1'b0, 1'b0);
    access(1'b0, DOORBELL, 8'h00, 0, 1'b0, 1'b0, 1'b0);
    access(1'b1, 11'h000, 8'h7e, 0, 1'b1, 1'b0, 1'b0);
    idle(2, 1'b0);

    // Reset in the middle of a doorbell write, then a normal access
    access(1'b1, DOORBELL, 8'h44, 0, 1'b0, 1'b0, 1'b1);
    idle(2, 1'b0);
    access(1'b0, 11'h123, 8'h00, 0, 1'b0, 1'b0, 1'b0);
    access(1'b0, DOORBELL, 8'h00, 0, 1'b0, 1'b0, 1'b0);

    // Randomised traffic
    ack_pct = 15;
    for (int n = 0; n < 40; n++) begin
      logic [AW-1:0] a;
      int sel = $urandom_range(0, 9);
      a = (sel == 0) ? DOORBELL : (sel == 1) ? 11'h000 : (sel < 5) ? AW'($urandom_range(0, 7)) : AW'($urandom);
      access(1'($urandom_range(0, 1)), a, 8'($urandom), $urandom_range(0, 2),
             ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0), 1'b0);
      idle($urandom_range(0, 3), 1'b0);
    end
    ack_pct = 0;
    idle(6, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
